// File: rtl/hash_cmd_master.sv
// hash_cmd_master: single-outstanding host-to-hash-table command/response front end.
// Optional response watchdog enabled by defining HASH_CMD_TIMEOUT_EN.
module hash_cmd_master #(
  parameter int KEY_WIDTH      = 5,
  parameter int DATA_WIDTH     = 25,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            req_valid_i,
  output logic                            req_ready_o,
  input  logic [1:0]                      req_op_i,
  input  logic [KEY_WIDTH-1:0]            req_key_i,
  input  logic [DATA_WIDTH-1:0]           req_data_i,
  output logic                            resp_valid_o,
  input  logic                            resp_ready_i,
  output logic [KEY_WIDTH-1:0]            resp_key_o,
  output logic [DATA_WIDTH-1:0]           resp_data_o,
  output logic [2:0]                      resp_status_o,
  output logic [2+KEY_WIDTH+DATA_WIDTH-1:0] tbl_data_o,
  output logic                            tbl_valid_o,
  input  logic                            tbl_ready_i,
  input  logic [31:0]                     tbl_data_i,
  input  logic                            tbl_valid_i,
  output logic                            tbl_ready_o,
  output logic [15:0]                     err_count_o
);
  typedef enum logic [1:0] {IDLE, SEND, WAIT, REPLY} state_t;
  state_t                  r_state, w_next;
  logic [1:0]              r_op;
  logic [KEY_WIDTH-1:0]    r_key;
  logic [DATA_WIDTH-1:0]   r_data, r_resp_data;
  logic [2:0]              r_status;
  logic [15:0]             r_err;
  logic [3:0]              w_flags;
  logic                    w_multi, w_timeout, w_enter_reply, w_stray, w_unused;
  logic [2:0]              w_flag_status, w_status;
  logic [1:0]              w_inc;
  logic [16:0]             w_sum;

`ifdef HASH_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_wdog;
  // Counts WAIT cycles; held at zero outside WAIT so every entry starts fresh.
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_wdog <= '0;
    else        r_wdog <= (r_state == WAIT) ? r_wdog + 1'b1 : '0;
  assign w_timeout = (r_state == WAIT) && (r_wdog == TW'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_to;
  assign w_unused_to = (TIMEOUT_CYCLES > 0);
  assign w_timeout   = 1'b0;
`endif

  assign w_unused = ^tbl_data_i[27:DATA_WIDTH];
  assign w_flags  = tbl_data_i[31:28];
  // More than one flag set iff clearing the lowest set bit leaves something.
  assign w_multi  = |(w_flags & (w_flags - 4'd1));
  assign w_flag_status = (w_flags == 4'd0) ? 3'd0 :
                         w_multi           ? 3'd7 :
                         w_flags[3]        ? 3'd1 :
                         w_flags[2]        ? 3'd2 :
                         w_flags[1]        ? 3'd3 : 3'd4;
  // A live response beats a same-cycle watchdog expiry.
  assign w_status = (r_state == IDLE)         ? 3'd5 :
                    (w_timeout && !tbl_valid_i) ? 3'd6 : w_flag_status;
  assign w_enter_reply = (r_state == IDLE && req_valid_i && req_op_i == 2'b00) ||
                         (r_state == WAIT && (tbl_valid_i || w_timeout));
  assign w_stray = (r_state == IDLE) && tbl_valid_i;
  assign w_inc   = 2'(w_enter_reply && w_status != 3'd0) + 2'(w_stray);
  assign w_sum   = {1'b0, r_err} + 17'(w_inc);

  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (req_valid_i)              w_next = (req_op_i == 2'b00) ? REPLY : SEND;
      SEND:  if (tbl_ready_i)              w_next = WAIT;
      WAIT:  if (tbl_valid_i || w_timeout) w_next = REPLY;
      REPLY: if (resp_ready_i)             w_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o  = (r_state == IDLE);
    tbl_valid_o  = (r_state == SEND);
    tbl_ready_o  = (r_state == IDLE) || (r_state == WAIT);
    resp_valid_o = (r_state == REPLY);
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_op        <= '0;
      r_key       <= '0;
      r_data      <= '0;
      r_status    <= '0;
      r_resp_data <= '0;
      r_err       <= '0;
    end else begin
      if (r_state == IDLE && req_valid_i) begin
        r_key <= req_key_i;
        if (req_op_i != 2'b00) begin
          r_op   <= req_op_i;
          r_data <= (req_op_i == 2'b10) ? req_data_i : '0;
        end
      end
      if (w_enter_reply) begin
        r_status    <= w_status;
        r_resp_data <= (r_state == WAIT && tbl_valid_i && r_op == 2'b01 && w_flag_status == 3'd0)
                       ? tbl_data_i[DATA_WIDTH-1:0] : '0;
      end
      r_err <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
    end

  assign tbl_data_o    = {r_op, r_key, r_data};
  assign resp_key_o    = r_key;
  assign resp_data_o   = r_resp_data;
  assign resp_status_o = r_status;
  assign err_count_o   = r_err;
endmodule
